// File: rtl/mux_scan_ctrl.sv
// Round-robin scan controller for a 4:1 mux: steps the selects a..d, dwells, captures y per channel.
// Optional per-channel change flags are enabled with `define MUX_SCAN_CHANGE_DETECT_EN.
module mux_scan_ctrl #(
   parameter int W     = 2,
   parameter int DWELL = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         cont,
   output logic         s0,
   output logic         s1,
   input  logic [W-1:0] y,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] ch0,
   output logic [W-1:0] ch1,
   output logic [W-1:0] ch2,
   output logic [W-1:0] ch3,
   output logic [3:0]   changed
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          ch_q, ch_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [3:0][W-1:0]   res_q, res_d;
   logic                capture;

   assign capture = (state_q == SCAN) && (cnt_q == LAST);

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            ch_d  = 2'd0;
            cnt_d = '0;
            if (start) begin
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (capture) begin
               cnt_d       = '0;
               res_d[ch_q] = y;
               // Channel d wraps the index back to a, so DONE already presents channel a.
               ch_d        = ch_q + 2'd1;
               if (ch_q == 2'd3) begin
                  state_d = DONE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            ch_d    = 2'd0;
            cnt_d   = '0;
            state_d = cont ? SCAN : IDLE;
         end
         default: begin
            state_d = IDLE;
            ch_d    = 2'd0;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ch_q    <= 2'd0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         res_q   <= res_d;
      end
   end

`ifdef MUX_SCAN_CHANGE_DETECT_EN
   logic [3:0] changed_q, changed_d;

   // Compare against the value being overwritten; results start at zero after reset.
   always_comb begin
      changed_d = changed_q;
      if (capture) begin
         changed_d[ch_q] = (y != res_q[ch_q]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         changed_q <= 4'b0000;
      end else begin
         changed_q <= changed_d;
      end
   end

   assign changed = changed_q;
`else
   assign changed = 4'b0000;
`endif

   assign s0   = ch_q[1];
   assign s1   = ch_q[0];
   assign busy = busy_q;
   assign done = done_q;
   assign ch0  = res_q[0];
   assign ch1  = res_q[1];
   assign ch2  = res_q[2];
   assign ch3  = res_q[3];

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Round-robin scan controller that sits directly upstream of the 4:1 two-bit multiplexer and drives its select lines. It also consumes the multiplexer output `y`. On a start request it steps the selects through channels a, b, c, d, holds each one for a programmable dwell time, and captures `y` into a per-channel result register at the end of each dwell. A one-cycle `done` pulse marks a complete four-channel scan. A continuous mode re-arms the scan automatically.

## Interface
Parameters:
- `W`, 2, data width of `y` and of each result register.
- `DWELL`, 4, clock cycles each channel is held (minimum 1); dwell counter width = max(1, $clog2(DWELL)).

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, asynchronous and active-high.
- `start`  input  1  scan request, sampled only in IDLE.
- `cont`  input  1  continuous mode; sampled at end of each scan.
- `s0`  output  1  mux select MSB (channel index bit 1).
- `s1`  output  1  mux select LSB (channel index bit 0).
- `y`  input  W  mux output.
- `busy`  output  1  high while scanning.
- `done`  output  1  one-cycle pulse after channel d is captured.
- `ch0`..`ch3`  output  W each  captured results for a, b, c, d.
- `changed`  output  4  per-channel change flags (see Configuration).

## Operation
- Channel index `ch[1:0]` maps to the selects as `s0 = ch[1]` and `s1 = ch[0]`:
  - a = 00
  - b = 01 (`s1` = 1)
  - c = 10 (`s0` = 1)
  - d = 11
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - `ch` = 0, `busy` = 0.
  - `start` = 1 → SCAN with `ch` = 0 and dwell count = 0.
- SCAN:
  - `busy` = 1; the dwell counter increments each cycle.
  - When count == DWELL-1: `ch<ch>` <= `y`, the count clears, and `ch` increments.
  - After the capture with `ch` == 3 → DONE.
- DONE: lasts one cycle with `done` = 1.
  - `cont` = 1 → SCAN with `ch` = 0. `busy` stays 1.
  - Otherwise → IDLE.
- `start` is ignored outside IDLE.
- `start` and `cont` are independent; `cont` alone does not begin a scan from IDLE.
- Dropping `cont` mid-scan lets the current scan finish, then the block returns to IDLE.
- Results hold their value until overwritten by a later capture of the same channel.
- Reset, including mid-scan, takes effect immediately:
  - State = IDLE, `ch` = 0, counter = 0.
  - `s0` = `s1` = 0, `busy` = `done` = 0.
  - `ch0`..`ch3` = 0, `changed` = 0.
  - No partial results are retained.

## Timing
- All outputs are registered; `s0`/`s1` come straight from the `ch` register.
- Let E0 be the edge at which `start` is sampled high in IDLE:
  - The selects present channel k during edges E0+k·DWELL through E0+(k+1)·DWELL.
  - Channel k is captured at edge E0+(k+1)·DWELL, and `ch<k>` is valid after that edge.
- `y` is sampled DWELL cycles after the select change. With DWELL=1, it is sampled one cycle after the select change.
- `done` is high for the cycle following edge E0+4·DWELL.
- Scan latency from `start` to `done` is 4·DWELL+1 cycles.
- In continuous mode, back-to-back scans are 4·DWELL+1 cycles apart. The DONE cycle presents `ch` = 0, giving channel a one extra settle cycle.

## Configuration
- Macro: `MUX_SCAN_CHANGE_DETECT_EN`.
- Defined:
  - At each capture, `changed[k]` <= (`y` != previous `ch<k>`).
  - The flag holds until that channel's next capture.
  - The first scan after reset compares against 0.
- Undefined: `changed` is tied to 4'b0000, with no comparator logic.

## Test plan
- Reset mid-scan (assert `rst` during the channel-b dwell):
  - Required: immediately `s0` = `s1` = 0, `busy` = 0, all results 0.
  - After release, no activity until `start`.
- Single scan, DWELL=4, `y` driven by the real mux (a=01, b=10, c=11, d=00), `start` pulsed:
  - Select sequence 00, 01, 10, 11, with 4 cycles each.
  - Result: `ch0`=01, `ch1`=10, `ch2`=11, `ch3`=00.
  - `done` pulses exactly once, 17 cycles after the `start` edge; then `busy` = 0.
- `start` held high for the whole scan with `cont` = 0:
  - Exactly one scan; a new scan starts only from the IDLE cycle after DONE.
- Continuous mode, `cont` = 1, then dropped during the second scan:
  - Exactly two `done` pulses, 17 cycles apart; `busy` stays 1 between them; then IDLE.
- DWELL=1 boundary:
  - Channel changes every cycle; `done` arrives 5 cycles after `start`; captures still correct.
- With the macro defined, repeat a scan with b changed from 10 to 01:
  - `changed` = 4'b0010 after the second scan.
  - A third identical scan gives `changed` = 4'b0000.
